// File: rtl/lfsr_pkg.sv
// Shared constants and types for the 80-bit Fibonacci LFSR.
package lfsr_pkg;

  localparam int unsigned LFSR_WIDTH = 80;

  // Taps for x^80 + x^79 + x^43 + x^42 + 1 (maximal length)
  localparam int unsigned TAP_A = 79;
  localparam int unsigned TAP_B = 78;
  localparam int unsigned TAP_C = 42;
  localparam int unsigned TAP_D = 41;

  typedef logic [LFSR_WIDTH-1:0] lfsr_state_t;

endpackage

// File: rtl/lfsr_feedback.sv
// Combinational feedback bit: XOR of the four tap bits of the LFSR state.
module lfsr_feedback (
  input  logic [3:0] taps,
  output logic       fb
);

  assign fb = ^taps;

endmodule

// File: rtl/lfsr80.sv
// 80-bit Fibonacci LFSR with parallel seed load, right shift, serial out at bit 0.
// Optional LFSR_ZERO_GUARD_EN: a shift from the all-zero state yields 80'h1.
module lfsr80
  import lfsr_pkg::*;
#(
  parameter int unsigned           WIDTH       = LFSR_WIDTH,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             Par_load,
  input  logic [WIDTH-1:0] Seed,
  output logic [WIDTH-1:0] Par_out,
  output logic             Ser_out
);

  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] shift_next;
  logic [3:0]       taps;
  logic             fb;

  assign taps = {state[TAP_A], state[TAP_B], state[TAP_C], state[TAP_D]};

  lfsr_feedback u_feedback (
    .taps (taps),
    .fb   (fb)
  );

  always_comb begin
    shift_next = {fb, state[WIDTH-1:1]};
`ifdef LFSR_ZERO_GUARD_EN
    // Escape the lock-up state instead of staying at zero
    if (state == '0) begin
      shift_next = WIDTH'(1);
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RESET_VALUE;
    end else if (Par_load) begin
      state <= Seed;
    end else if (shift_en) begin
      state <= shift_next;
    end
  end

  assign Par_out = state;
  assign Ser_out = state[0];

endmodule

// File: tb/tb_lfsr80.sv
// Self-checking bench for lfsr80: directed sequence plus randomized traffic vs a reference model.
module tb_lfsr80;

  localparam logic [79:0] TAP_MASK = (80'h1 << 79) | (80'h1 << 78) | (80'h1 << 42) | (80'h1 << 41);
  localparam logic [79:0] SEED_A   = 80'habcdef012345abcdef67;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        shift_en = 1'b0;
  logic        Par_load = 1'b0;
  logic [79:0] Seed = '0;
  logic [79:0] Par_out;
  logic        Ser_out;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [79:0] model = '0;

  lfsr80 dut (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en),
    .Par_load (Par_load),
    .Seed     (Seed),
    .Par_out  (Par_out),
    .Ser_out  (Ser_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: feedback is the parity of the tapped bits, new bit enters at the MSB.
  function automatic logic [79:0] ref_shift(input logic [79:0] s);
    logic [79:0] nxt;
    logic        fb;
    fb  = ($countones(s & TAP_MASK) % 2) == 1;
    nxt = (s >> 1) | (fb ? (80'h1 << 79) : 80'h0);
`ifdef LFSR_ZERO_GUARD_EN
    if (s == 80'h0) nxt = 80'h1;
`endif
    return nxt;
  endfunction

  task automatic clock_step(input string tag);
    @(posedge clk);
    if (rst)           model = '0;
    else if (Par_load) model = Seed;
    else if (shift_en) model = ref_shift(model);
    #1;
    check({tag, "_par"}, Par_out, model);
    check({tag, "_ser"}, {79'b0, Ser_out}, {79'b0, model[0]});
  endtask

  task automatic async_reset_pulse(input string tag);
    #2 rst = 1'b1;
    #1;
    model = '0;
    check({tag, "_rst_par"}, Par_out, 80'h0);
    check({tag, "_rst_ser"}, {79'b0, Ser_out}, 80'h0);
    rst = 1'b0;
  endtask

  initial begin
    logic [79:0] zero_shift_exp;

    // Asynchronous reset before any clock edge, with load requested
    #2;
    rst = 1'b1; Seed = SEED_A; Par_load = 1'b1;
    #1;
    check("reset_async_par", Par_out, 80'h0);
    check("reset_async_ser", {79'b0, Ser_out}, 80'h0);
    clock_step("reset_hold");
    clock_step("reset_hold2");
    rst = 1'b0;

    clock_step("load_seed");
    check("load_seed_const", Par_out, SEED_A);
    check("load_seed_ser", {79'b0, Ser_out}, 80'h1);

    Par_load = 1'b0; shift_en = 1'b1;
    clock_step("first_shift");
    check("first_shift_const", Par_out, 80'h55e6f78091a2d5e6f7b3);

    Par_load = 1'b1; shift_en = 1'b1; Seed = 80'h1;
    clock_step("load_prio");
    check("load_prio_const", Par_out, 80'h1);

    Par_load = 1'b0; shift_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      clock_step("hold");
      check("hold_const", Par_out, 80'h1);
    end

    Par_load = 1'b1; Seed = SEED_A;
    clock_step("reload");
    Par_load = 1'b0; shift_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      check("ser_before_edge", {79'b0, Ser_out}, {79'b0, model[0]});
      clock_step("shift_run");
    end

    // Zero seed then shift
    Par_load = 1'b1; shift_en = 1'b0; Seed = 80'h0;
    clock_step("zero_load");
    Par_load = 1'b0; shift_en = 1'b1;
    clock_step("zero_shift");
`ifdef LFSR_ZERO_GUARD_EN
    zero_shift_exp = 80'h1;
`else
    zero_shift_exp = 80'h0;
`endif
    check("zero_shift_const", Par_out, zero_shift_exp);

    // Reset in the middle of a shift run
    Par_load = 1'b1; Seed = SEED_A;
    clock_step("pre_rst_load");
    Par_load = 1'b0; shift_en = 1'b1;
    clock_step("pre_rst_shift");
    async_reset_pulse("mid_shift");
    clock_step("post_rst");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      Par_load = ($urandom_range(0, 7) == 0);
      shift_en = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0:       Seed = 80'h0;
        1:       Seed = 80'h1;
        default: Seed = {$urandom(), $urandom(), $urandom()} & {80{1'b1}};
      endcase
      if ($urandom_range(0, 39) == 0) async_reset_pulse("rand");
      clock_step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=%0d", 0, 1);
    $fatal(1, "timeout");
  end

endmodule
